dcm_prog_ctrl: RTL and testbench

Programming controller for the board clock manager. Arbitrates rate-change requests from two external requesters plus an optional internal auto-sweep source, issues the single-cycle `update` strobe and 3-bit program code to the clock manager, waits a settle interval, then acknowledges the winner. Sits between user-facing logic (switch/button front end, host command decoder) and the clock manager's `update`/`prog_in` inputs.

---
 rtl/dcm_prog_ctrl_if.sv | 26 ++
 rtl/dcm_prog_ctrl.sv | 135 +++++++++++++
 tb/tb_dcm_prog_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcm_prog_ctrl_if.sv
// Request/acknowledge and program-code bundle between the requesters and dcm_prog_ctrl.
interface dcm_prog_ctrl_if;
  localparam int unsigned PROG_W = 3;

  logic              req_a;
  logic [PROG_W-1:0] prog_a;
  logic              req_b;
  logic [PROG_W-1:0] prog_b;
  logic              sweep_en;
  logic              ack_a;
  logic              ack_b;
  logic              update;
  logic [PROG_W-1:0] prog_out;
  logic [PROG_W-1:0] prog_cur;
  logic              busy;

  modport master (
    output req_a, prog_a, req_b, prog_b, sweep_en,
    input  ack_a, ack_b, update, prog_out, prog_cur, busy
  );

  modport slave (
    input  req_a, prog_a, req_b, prog_b, sweep_en,
    output ack_a, ack_b, update, prog_out, prog_cur, busy
  );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// Clock-manager programming controller: round-robin A/B arbitration, update strobe, settle wait, ack.
// Optional auto-sweep source compiled in with `define DCM_PROG_CTRL_SWEEP_EN.
module dcm_prog_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SWEEP_DWELL   = 100000000
) (
  input logic            clock,
  input logic            reset,
  dcm_prog_ctrl_if.slave bus
);
  localparam int unsigned PW  = 3;
  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, ACK} state_t;
  typedef enum logic [1:0] {W_A, W_B, W_SWEEP} win_t;

  state_t          state_q, state_d;
  win_t            win_q, win_d;
  logic            rr_q, rr_d;
  logic            grant_c;
  logic [SCW-1:0]  settle_q;
  logic [PW-1:0]   code_d;
  logic [PW-1:0]   prog_out_q;
  logic [PW-1:0]   prog_cur_q, prog_cur_d;
  logic            update_q, update_d;
  logic            busy_q, busy_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;
  logic            sweep_req_c;

`ifdef DCM_PROG_CTRL_SWEEP_EN
  localparam logic [31:0] DWELL_LAST = 32'(SWEEP_DWELL - 1);
  logic [31:0] dwell_q;

  assign sweep_req_c = bus.sweep_en && (dwell_q == DWELL_LAST);

  // Dwell only advances while idle with nothing external waiting; any rate change restarts it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dwell_q <= '0;
    end else if (!bus.sweep_en || state_q == ISSUE || dwell_q == DWELL_LAST) begin
      dwell_q <= '0;
    end else if (state_q == IDLE && !bus.req_a && !bus.req_b) begin
      dwell_q <= dwell_q + 32'd1;
    end
  end
`else
  logic        sweep_en_unused;
  logic [31:0] sweep_dwell_unused;
  assign sweep_en_unused    = bus.sweep_en;
  assign sweep_dwell_unused = 32'(SWEEP_DWELL);
  assign sweep_req_c        = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      win_q      <= W_A;
      rr_q       <= 1'b0;
      settle_q   <= '0;
      prog_out_q <= '0;
      prog_cur_q <= '0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      rr_q       <= rr_d;
      settle_q   <= (state_q == SETTLE) ? settle_q + SCW'(1) : '0;
      prog_out_q <= code_d;
      prog_cur_q <= prog_cur_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
    end
  end

  // Arbitration and next state; the RR pointer only moves when A and B contend.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    grant_c = 1'b0;
    code_d  = prog_out_q;
    if (state_q == IDLE) begin
      if (bus.req_a && bus.req_b) begin
        grant_c = 1'b1;
        win_d   = rr_q ? W_B : W_A;
        rr_d    = ~rr_q;
      end else if (bus.req_a) begin
        grant_c = 1'b1;
        win_d   = W_A;
      end else if (bus.req_b) begin
        grant_c = 1'b1;
        win_d   = W_B;
      end else if (sweep_req_c) begin
        grant_c = 1'b1;
        win_d   = W_SWEEP;
      end
      if (grant_c) begin
        case (win_d)
          W_A:     code_d = bus.prog_a;
          W_B:     code_d = bus.prog_b;
          default: code_d = prog_cur_q + PW'(1);
        endcase
      end
    end
    unique case (state_q)
      IDLE:   if (grant_c) state_d = (code_d == prog_cur_q) ? ACK : ISSUE;
      ISSUE:  state_d = SETTLE;
      SETTLE: if (settle_q == SCW'(SETTLE_CYCLES - 1)) state_d = ACK;
      ACK:    state_d = IDLE;
    endcase
  end

  // Output values registered alongside the state they belong to.
  always_comb begin
    update_d   = (state_d == ISSUE);
    busy_d     = (state_d != IDLE);
    ack_a_d    = (state_d == ACK) && (win_d == W_A);
    ack_b_d    = (state_d == ACK) && (win_d == W_B);
    prog_cur_d = (state_d == ISSUE) ? code_d : prog_cur_q;
  end

  assign bus.update   = update_q;
  assign bus.prog_out = prog_out_q;
  assign bus.prog_cur = prog_cur_q;
  assign bus.busy     = busy_q;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Self-checking bench for dcm_prog_ctrl: directed scenarios plus randomized A/B traffic against a timing model.
module tb_dcm_prog_ctrl;
  localparam int unsigned S  = 16;
  localparam int unsigned DW = 50;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Model state: last committed code and contention pointer (0 = A next).
  logic [2:0] m_cur;
  logic       m_rr;

  // Observed events from the current window.
  int         upd_cyc[$];
  logic [2:0] upd_code[$];
  int         acka_cyc[$];
  int         ackb_cyc[$];
  int         busy_cnt;

  dcm_prog_ctrl_if bus();

  dcm_prog_ctrl #(.SETTLE_CYCLES(S), .SWEEP_DWELL(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic clear_obs();
    upd_cyc.delete(); upd_code.delete(); acka_cyc.delete(); ackb_cyc.delete();
    busy_cnt = 0;
  endtask

  // Records outputs for n cycles; requesters drop their request once acked when auto_drop is set.
  task automatic observe(input int n, input bit auto_drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.update) begin upd_cyc.push_back(cyc); upd_code.push_back(bus.prog_out); end
      if (bus.ack_a) begin acka_cyc.push_back(cyc); if (auto_drop) bus.req_a = 1'b0; end
      if (bus.ack_b) begin ackb_cyc.push_back(cyc); if (auto_drop) bus.req_b = 1'b0; end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.sweep_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_cur = 3'd0;
    m_rr  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.req_a = 1'b1; bus.prog_a = 3'd5;
    repeat (2) @(negedge clock);
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", bus.update); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0) begin errors++; $display("FAIL reset_ack got %b%b exp 00", bus.ack_a, bus.ack_b); end
    checks++; if (bus.prog_out !== 3'd0) begin errors++; $display("FAIL reset_prog_out got %0d exp 0", bus.prog_out); end
    checks++; if (bus.prog_cur !== 3'd0) begin errors++; $display("FAIL reset_prog_cur got %0d exp 0", bus.prog_cur); end
    bus.req_a = 1'b0;
    reset = 1'b1;
    m_cur = 3'd0;
    m_rr  = 1'b0;
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    repeat (10) @(negedge clock);
    bus.req_a = 1'b1; bus.prog_a = 3'd3;
    n = cyc;
    clear_obs();
    observe(S + 8, 1'b1);
    checks++;
    if (upd_cyc.size() != 1) begin errors++; $display("FAIL single_update_count got %0d exp 1", upd_cyc.size()); end
    else begin
      checks++; if (upd_cyc[0] != n + 1) begin errors++; $display("FAIL single_update_cycle got %0d exp %0d", upd_cyc[0], n + 1); end
      checks++; if (upd_code[0] !== 3'd3) begin errors++; $display("FAIL single_prog_out got %0d exp 3", upd_code[0]); end
    end
    checks++;
    if (acka_cyc.size() != 1 || acka_cyc[0] != n + 2 + int'(S)) begin
      errors++; $display("FAIL single_ack_a got %0d acks first %0d exp 1 ack at %0d", acka_cyc.size(),
                         (acka_cyc.size() > 0) ? acka_cyc[0] : -1, n + 2 + int'(S));
    end
    checks++; if (busy_cnt != int'(S) + 2) begin errors++; $display("FAIL single_busy_cycles got %0d exp %0d", busy_cnt, S + 2); end
    checks++; if (bus.prog_cur !== 3'd3) begin errors++; $display("FAIL single_prog_cur got %0d exp 3", bus.prog_cur); end
    m_cur = 3'd3;
  endtask

  task automatic test_same_code();
    int n;
    @(negedge clock);
    bus.req_b = 1'b1; bus.prog_b = m_cur;
    n = cyc;
    clear_obs();
    observe(8, 1'b1);
    checks++; if (upd_cyc.size() != 0) begin errors++; $display("FAIL same_update_count got %0d exp 0", upd_cyc.size()); end
    checks++;
    if (ackb_cyc.size() != 1 || ackb_cyc[0] != n + 1) begin
      errors++; $display("FAIL same_ack_b got %0d acks first %0d exp 1 ack at %0d", ackb_cyc.size(),
                         (ackb_cyc.size() > 0) ? ackb_cyc[0] : -1, n + 1);
    end
    checks++; if (busy_cnt != 1) begin errors++; $display("FAIL same_busy_cycles got %0d exp 1", busy_cnt); end
    checks++; if (bus.prog_out !== m_cur) begin errors++; $display("FAIL same_prog_out got %0d exp %0d", bus.prog_out, m_cur); end
  endtask

  task automatic test_back_to_back();
    int         n;
    logic [2:0] ca[2];
    logic [2:0] cb[2];
    ca[0] = 3'd5; cb[0] = 3'd6; ca[1] = 3'd1; cb[1] = 3'd2;
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      int first_ack;
      int second_ack;
      @(negedge clock);
      bus.req_a = 1'b1; bus.prog_a = ca[p];
      bus.req_b = 1'b1; bus.prog_b = cb[p];
      n = cyc;
      clear_obs();
      observe(2 * (S + 3) + 4, 1'b1);
      first_ack  = n + 2 + int'(S);
      second_ack = first_ack + 3 + int'(S);
      checks++;
      if (upd_cyc.size() != 2) begin errors++; $display("FAIL b2b%0d_update_count got %0d exp 2", p, upd_cyc.size()); end
      else begin
        checks++;
        if (upd_code[0] !== ((p == 0) ? ca[p] : cb[p]) || upd_code[1] !== ((p == 0) ? cb[p] : ca[p])) begin
          errors++; $display("FAIL b2b%0d_grant_order got %0d,%0d exp %0d,%0d", p, upd_code[0], upd_code[1],
                             (p == 0) ? ca[p] : cb[p], (p == 0) ? cb[p] : ca[p]);
        end
        checks++;
        if (upd_cyc[0] != n + 1 || upd_cyc[1] != first_ack + 2) begin
          errors++; $display("FAIL b2b%0d_update_cycles got %0d,%0d exp %0d,%0d", p, upd_cyc[0], upd_cyc[1], n + 1, first_ack + 2);
        end
      end
      checks++;
      if (acka_cyc.size() != 1 || ackb_cyc.size() != 1 ||
          acka_cyc[0] != ((p == 0) ? first_ack : second_ack) || ackb_cyc[0] != ((p == 0) ? second_ack : first_ack)) begin
        errors++; $display("FAIL b2b%0d_acks got a=%0d b=%0d exp a=%0d b=%0d", p,
                           (acka_cyc.size() > 0) ? acka_cyc[0] : -1, (ackb_cyc.size() > 0) ? ackb_cyc[0] : -1,
                           (p == 0) ? first_ack : second_ack, (p == 0) ? second_ack : first_ack);
      end
    end
    m_cur = 3'd1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 24; t++) begin
      int         exp_u[$];
      logic [2:0] exp_c[$];
      int         exp_a[$];
      int         exp_b[$];
      int         exp_busy;
      int         kind;
      int         n;
      int         ts;
      int         order[$];
      logic [2:0] ca;
      logic [2:0] cb;
      kind = int'($urandom_range(0, 2));
      ca = ($urandom_range(0, 2) == 0) ? m_cur : 3'($urandom_range(0, 7));
      cb = ($urandom_range(0, 2) == 0) ? m_cur : 3'($urandom_range(0, 7));
      @(negedge clock);
      if (kind != 1) begin bus.req_a = 1'b1; bus.prog_a = ca; end
      if (kind != 0) begin bus.req_b = 1'b1; bus.prog_b = cb; end
      n = cyc;
      if (kind == 0) order.push_back(0);
      else if (kind == 1) order.push_back(1);
      else begin
        order.push_back(int'(m_rr)); order.push_back(int'(!m_rr));
        m_rr = !m_rr;
      end
      ts = n;
      exp_busy = 0;
      foreach (order[k]) begin
        logic [2:0] c;
        int         lat;
        c = (order[k] == 0) ? ca : cb;
        if (c == m_cur) lat = 1;
        else begin
          lat = int'(S) + 2;
          exp_u.push_back(ts + 1); exp_c.push_back(c);
          m_cur = c;
        end
        if (order[k] == 0) exp_a.push_back(ts + lat); else exp_b.push_back(ts + lat);
        exp_busy += lat;
        ts = ts + lat + 1;
      end
      clear_obs();
      observe(2 * (S + 3) + 4, 1'b1);
      checks++;
      if (upd_cyc.size() != exp_u.size()) begin errors++; $display("FAIL rand%0d_update_count got %0d exp %0d", t, upd_cyc.size(), exp_u.size()); end
      else foreach (exp_u[i]) begin
        checks++;
        if (upd_cyc[i] != exp_u[i] || upd_code[i] !== exp_c[i]) begin
          errors++; $display("FAIL rand%0d_update%0d got cyc %0d code %0d exp cyc %0d code %0d", t, i, upd_cyc[i], upd_code[i], exp_u[i], exp_c[i]);
        end
      end
      checks++;
      if (acka_cyc != exp_a) begin errors++; $display("FAIL rand%0d_ack_a got %p exp %p", t, acka_cyc, exp_a); end
      checks++;
      if (ackb_cyc != exp_b) begin errors++; $display("FAIL rand%0d_ack_b got %p exp %p", t, ackb_cyc, exp_b); end
      checks++;
      if (busy_cnt != exp_busy) begin errors++; $display("FAIL rand%0d_busy_cycles got %0d exp %0d", t, busy_cnt, exp_busy); end
      checks++;
      if (bus.prog_cur !== m_cur) begin errors++; $display("FAIL rand%0d_prog_cur got %0d exp %0d", t, bus.prog_cur, m_cur); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clock);
    bus.req_a = 1'b1; bus.prog_a = 3'd4;
    repeat (6) @(negedge clock);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", bus.busy); end
    reset = 1'b0;
    bus.req_a = 1'b0;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.prog_cur !== 3'd0) begin errors++; $display("FAIL midrst_prog_cur got %0d exp 0", bus.prog_cur); end
    checks++; if (bus.update !== 1'b0 || bus.ack_a !== 1'b0) begin errors++; $display("FAIL midrst_strobes got upd %b ack %b exp 0 0", bus.update, bus.ack_a); end
    reset = 1'b1;
    m_cur = 3'd0;
    m_rr  = 1'b0;
    clear_obs();
    observe(S + 10, 1'b1);
    checks++;
    if (acka_cyc.size() != 0 || ackb_cyc.size() != 0 || upd_cyc.size() != 0) begin
      errors++; $display("FAIL midrst_after got acks %0d/%0d updates %0d exp 0/0 0", acka_cyc.size(), ackb_cyc.size(), upd_cyc.size());
    end
  endtask

`ifdef DCM_PROG_CTRL_SWEEP_EN
  task automatic test_sweep();
    int n;
    int idle0;
    apply_reset();
    @(negedge clock);
    bus.req_a = 1'b1; bus.prog_a = 3'd7; bus.sweep_en = 1'b1;
    n = cyc;
    idle0 = n + int'(S) + 3;
    clear_obs();
    observe(2 * (S + 3) + DW + 2, 1'b1);
    checks++;
    if (upd_cyc.size() != 2) begin errors++; $display("FAIL sweep_update_count got %0d exp 2", upd_cyc.size()); end
    else begin
      checks++;
      if (upd_cyc[1] != idle0 + int'(DW) || upd_code[1] !== 3'd0) begin
        errors++; $display("FAIL sweep_step got cyc %0d code %0d exp cyc %0d code 0", upd_cyc[1], upd_code[1], idle0 + int'(DW));
      end
    end
    checks++; if (acka_cyc.size() != 1 || ackb_cyc.size() != 0) begin errors++; $display("FAIL sweep_acks got a %0d b %0d exp 1 0", acka_cyc.size(), ackb_cyc.size()); end
    checks++; if (bus.prog_cur !== 3'd0) begin errors++; $display("FAIL sweep_prog_cur got %0d exp 0", bus.prog_cur); end
    @(negedge clock);
    bus.req_a = 1'b1; bus.prog_a = 3'd0;
    clear_obs();
    observe(3 * DW, 1'b0);
    checks++; if (upd_cyc.size() != 0) begin errors++; $display("FAIL sweep_starved got %0d updates exp 0", upd_cyc.size()); end
    checks++; if (acka_cyc.size() != int'(3 * DW) / 2) begin errors++; $display("FAIL sweep_held_acks got %0d exp %0d", acka_cyc.size(), (3 * DW) / 2); end
    bus.req_a = 1'b0; bus.sweep_en = 1'b0;
    m_cur = 3'd0;
  endtask
`else
  task automatic test_no_sweep();
    apply_reset();
    bus.sweep_en = 1'b1;
    clear_obs();
    observe(1000, 1'b1);
    checks++; if (upd_cyc.size() != 0) begin errors++; $display("FAIL nosweep_updates got %0d exp 0", upd_cyc.size()); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL nosweep_busy got %0d exp 0", busy_cnt); end
    bus.sweep_en = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    bus.req_a = 1'b0; bus.prog_a = 3'd0;
    bus.req_b = 1'b0; bus.prog_b = 3'd0;
    bus.sweep_en = 1'b0;
    m_cur = 3'd0;
    m_rr  = 1'b0;
    test_reset();
    test_single();
    test_same_code();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef DCM_PROG_CTRL_SWEEP_EN
    test_sweep();
`else
    test_no_sweep();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
